code_server: RTL and testbench

Program-memory responder for the synapse316 core's instruction fetch port. It owns the program RAM and holds the core in reset while a program image is streamed in over a valid/ready load port. It then releases the core and answers every `code_addr` with `code_in` and a `code_ready` qualifier, one cycle after the address is presented.

---
 rtl/code_server_pkg.sv | 15 +
 rtl/code_server_ram.sv | 28 ++
 rtl/code_server.sv | 123 ++++++++++++
 tb/tb_code_server.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/code_server_pkg.sv
// Shared types and constants for the code_server program-memory responder.
package code_server_pkg;

  typedef enum logic {
    CS_LOAD,
    CS_RUN
  } cs_state_t;

  localparam int unsigned CS_DEFAULT_ADDR_WIDTH = 10;
  localparam int unsigned CS_WORD_WIDTH         = 16;

  // Returned for fetches whose address lies beyond the RAM.
  localparam logic [CS_WORD_WIDTH-1:0] CS_FILL_WORD = 16'h0000;

endpackage

// File: rtl/code_server_ram.sv
// Single-port synchronous RAM with a registered read port, shaped to infer block RAM.
module code_ram #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Contents are deliberately not reset; a restart only rewinds the write pointer.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/code_server.sv
// Program-memory responder: holds the core in reset while an image is streamed
// into RAM, then serves instruction fetches with one cycle of latency.
module code_server
  import code_server_pkg::*;
#(
  parameter int unsigned IPR_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH = CS_DEFAULT_ADDR_WIDTH
) (
  input  logic                  sysclk,
  input  logic                  sysreset_n,
  input  logic [IPR_WIDTH-1:0]  code_addr,
  output logic [15:0]           code_in,
  output logic                  code_ready,
  output logic                  core_reset,
  input  logic                  load_valid,
  input  logic [15:0]           load_data,
  output logic                  load_ready,
  input  logic                  load_done,
  input  logic                  load_restart,
  output logic [ADDR_WIDTH:0]   load_count
);

  // wptr reaches 2**ADDR_WIDTH exactly when the RAM is full.
  localparam logic [ADDR_WIDTH:0] FullCount = {1'b1, {ADDR_WIDTH{1'b0}}};

  cs_state_t             state_q, state_d;
  logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
  logic                  core_reset_q, core_reset_d;
  logic [IPR_WIDTH-1:0]  fetched_addr_q, fetched_addr_d;
  logic                  fetched_valid_q, fetched_valid_d;

  logic                  in_load;
  logic                  full;
  logic                  accept;
  logic                  out_of_range;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [15:0]           ram_rdata;

  assign in_load = (state_q == CS_LOAD);
  assign full    = (wptr_q == FullCount);
  // A restart drops whatever word is offered in the same cycle.
  assign accept  = in_load && load_valid && !full && !load_restart;

  assign ram_addr = in_load ? wptr_q[ADDR_WIDTH-1:0] : code_addr[ADDR_WIDTH-1:0];

  code_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (16)
  ) u_code_ram (
    .clk_i   (sysclk),
    .we_i    (accept),
    .addr_i  (ram_addr),
    .wdata_i (load_data),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d         = state_q;
    wptr_d          = wptr_q;
    core_reset_d    = core_reset_q;
    fetched_addr_d  = fetched_addr_q;
    fetched_valid_d = fetched_valid_q;

    unique case (state_q)
      CS_LOAD: begin
        fetched_valid_d = 1'b0;
        if (load_restart) begin
          wptr_d = '0;
        end else begin
          if (accept) begin
            wptr_d = wptr_q + 1'b1;
          end
          if (load_done) begin
            state_d      = CS_RUN;
            core_reset_d = 1'b0;
          end
        end
      end
      CS_RUN: begin
        if (load_restart) begin
          state_d         = CS_LOAD;
          wptr_d          = '0;
          core_reset_d    = 1'b1;
          fetched_valid_d = 1'b0;
        end else begin
          fetched_addr_d  = code_addr;
          fetched_valid_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      state_q         <= CS_LOAD;
      wptr_q          <= '0;
      core_reset_q    <= 1'b1;
      fetched_addr_q  <= '0;
      fetched_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      wptr_q          <= wptr_d;
      core_reset_q    <= core_reset_d;
      fetched_addr_q  <= fetched_addr_d;
      fetched_valid_q <= fetched_valid_d;
    end
  end

  assign out_of_range = |fetched_addr_q[IPR_WIDTH-1:ADDR_WIDTH];

  always_comb begin
    code_in = 16'h0000;
    if (!in_load) begin
      code_in = out_of_range ? CS_FILL_WORD : ram_rdata;
    end
  end

  assign code_ready = !in_load && fetched_valid_q && (fetched_addr_q == code_addr);
  assign load_ready = in_load && !full;
  assign core_reset = core_reset_q;
  assign load_count = wptr_q;

endmodule

// File: tb/tb_code_server.sv
// Directed bench for code_server: a default-size instance and a 4-word instance.
module tb_code_server;

  logic        sysclk = 1'b0;
  logic        sysreset_n;

  // Default instance (ADDR_WIDTH = 10)
  logic [15:0] code_addr;
  logic [15:0] code_in;
  logic        code_ready, core_reset, load_valid, load_ready, load_done, load_restart;
  logic [15:0] load_data;
  logic [10:0] load_count;

  // Small instance (ADDR_WIDTH = 2)
  logic [15:0] s_code_addr;
  logic [15:0] s_code_in;
  logic        s_code_ready, s_core_reset, s_load_valid, s_load_ready, s_load_done;
  logic        s_load_restart;
  logic [15:0] s_load_data;
  logic [2:0]  s_load_count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 sysclk = ~sysclk;

  code_server #(
    .IPR_WIDTH  (16),
    .ADDR_WIDTH (10)
  ) u_dut (
    .sysclk       (sysclk),
    .sysreset_n   (sysreset_n),
    .code_addr    (code_addr),
    .code_in      (code_in),
    .code_ready   (code_ready),
    .core_reset   (core_reset),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_ready   (load_ready),
    .load_done    (load_done),
    .load_restart (load_restart),
    .load_count   (load_count)
  );

  code_server #(
    .IPR_WIDTH  (16),
    .ADDR_WIDTH (2)
  ) u_small (
    .sysclk       (sysclk),
    .sysreset_n   (sysreset_n),
    .code_addr    (s_code_addr),
    .code_in      (s_code_in),
    .code_ready   (s_code_ready),
    .core_reset   (s_core_reset),
    .load_valid   (s_load_valid),
    .load_data    (s_load_data),
    .load_ready   (s_load_ready),
    .load_done    (s_load_done),
    .load_restart (s_load_restart),
    .load_count   (s_load_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  initial begin
    sysreset_n     = 1'b0;
    code_addr      = '0;
    load_valid     = 1'b0;
    load_data      = '0;
    load_done      = 1'b0;
    load_restart   = 1'b0;
    s_code_addr    = '0;
    s_load_valid   = 1'b0;
    s_load_data    = '0;
    s_load_done    = 1'b0;
    s_load_restart = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_code_ready", 32'(code_ready), 32'd0);
    check("rst_load_ready", 32'(load_ready), 32'd1);
    check("rst_load_count", 32'(load_count), 32'd0);
    check("rst_code_in", 32'(code_in), 32'h0000);
    sysreset_n = 1'b1;

    // Reset asserted mid-stream
    load_valid = 1'b1;
    load_data  = 16'hDEAD;
    tick();
    load_data  = 16'hBEEF;
    tick();
    load_valid = 1'b0;
    check("midload_count", 32'(load_count), 32'd2);
    #2 sysreset_n = 1'b0;
    #1;
    check("async_rst_count", 32'(load_count), 32'd0);
    check("async_rst_core_reset", 32'(core_reset), 32'd1);
    check("async_rst_load_ready", 32'(load_ready), 32'd1);
    check("async_rst_code_ready", 32'(code_ready), 32'd0);
    tick();
    sysreset_n = 1'b1;

    // Load three words, done on the last
    load_valid = 1'b1;
    load_data  = 16'h1111;
    tick();
    load_data  = 16'h2222;
    tick();
    load_data  = 16'h3333;
    load_done  = 1'b1;
    check("pre_done_core_reset", 32'(core_reset), 32'd1);
    tick();
    load_valid = 1'b0;
    load_done  = 1'b0;
    check("run_load_count", 32'(load_count), 32'd3);
    check("run_core_reset", 32'(core_reset), 32'd0);
    check("run_load_ready", 32'(load_ready), 32'd0);
    check("run_first_ready", 32'(code_ready), 32'd0);
    code_addr = 16'd1;
    tick();
    check("fetch1_code_in", 32'(code_in), 32'h2222);
    check("fetch1_ready", 32'(code_ready), 32'd1);

    // Address change 0 -> 2 -> 2
    code_addr = 16'd0;
    tick();
    check("fetch0_ready", 32'(code_ready), 32'd1);
    check("fetch0_code_in", 32'(code_in), 32'h1111);
    code_addr = 16'd2;
    #1;
    check("addr_change_ready", 32'(code_ready), 32'd0);
    tick();
    check("fetch2_ready", 32'(code_ready), 32'd1);
    check("fetch2_code_in", 32'(code_in), 32'h3333);

    // Out-of-range fetch (RAM sees address 0, which holds 16'h1111)
    code_addr = 16'h0400;
    #1;
    check("oor_change_ready", 32'(code_ready), 32'd0);
    tick();
    check("oor_code_in", 32'(code_in), 32'h0000);
    check("oor_ready", 32'(code_ready), 32'd1);

    // Load port ignored in RUN
    load_valid = 1'b1;
    load_data  = 16'h5555;
    load_done  = 1'b1;
    tick();
    load_valid = 1'b0;
    load_done  = 1'b0;
    check("run_ignore_count", 32'(load_count), 32'd3);

    // Restart from RUN, reload one word
    load_restart = 1'b1;
    tick();
    load_restart = 1'b0;
    check("restart_core_reset", 32'(core_reset), 32'd1);
    check("restart_code_ready", 32'(code_ready), 32'd0);
    check("restart_load_count", 32'(load_count), 32'd0);
    check("restart_load_ready", 32'(load_ready), 32'd1);
    code_addr  = 16'd0;
    load_valid = 1'b1;
    load_data  = 16'hABCD;
    load_done  = 1'b1;
    tick();
    load_valid = 1'b0;
    load_done  = 1'b0;
    check("reload_core_reset", 32'(core_reset), 32'd0);
    check("reload_count", 32'(load_count), 32'd1);
    tick();
    check("reload_code_in", 32'(code_in), 32'hABCD);
    check("reload_ready", 32'(code_ready), 32'd1);

    // Restart in LOAD beats done and drops the offered word
    load_restart = 1'b1;
    tick();
    load_valid = 1'b1;
    load_data  = 16'h7777;
    load_done  = 1'b1;
    tick();
    load_restart = 1'b0;
    load_data    = 16'h9999;
    check("restart_wins_core_reset", 32'(core_reset), 32'd1);
    check("restart_drop_count", 32'(load_count), 32'd0);
    tick();
    load_valid = 1'b0;
    load_done  = 1'b0;
    tick();
    check("after_restart_code_in", 32'(code_in), 32'h9999);

    // load_done with nothing written keeps RAM contents
    load_restart = 1'b1;
    tick();
    load_restart = 1'b0;
    load_done    = 1'b1;
    tick();
    load_done = 1'b0;
    check("empty_done_core_reset", 32'(core_reset), 32'd0);
    check("empty_done_count", 32'(load_count), 32'd0);
    tick();
    check("empty_done_code_in", 32'(code_in), 32'h9999);
    check("empty_done_ready", 32'(code_ready), 32'd1);

    // Full boundary on the 4-word instance
    s_load_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_load_data = 16'hA000 + 16'(i);
      check($sformatf("small_ready_%0d", i), 32'(s_load_ready), (i < 4) ? 32'd1 : 32'd0);
      tick();
    end
    check("small_full_count", 32'(s_load_count), 32'd4);
    check("small_full_core_reset", 32'(s_core_reset), 32'd1);
    s_load_valid = 1'b0;
    s_load_done  = 1'b1;
    tick();
    s_load_done = 1'b0;
    check("small_run_core_reset", 32'(s_core_reset), 32'd0);
    s_code_addr = 16'd3;
    tick();
    check("small_fetch3", 32'(s_code_in), 32'hA003);
    check("small_fetch3_ready", 32'(s_code_ready), 32'd1);
    s_code_addr = 16'd0;
    tick();
    check("small_fetch0_no_wrap", 32'(s_code_in), 32'hA000);
    s_code_addr = 16'h0004;
    tick();
    check("small_oor_code_in", 32'(s_code_in), 32'h0000);
    check("small_oor_ready", 32'(s_code_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
